// File: rtl/button_event_arbiter_pkg.sv
// Shared types and helpers for the button event arbiter: FSM state encoding and a
// constant-foldable clog2 used to validate the event code width.
package button_event_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSend = 2'b01,
        StGap  = 2'b10
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/button_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request at or after ptr,
// wrapping around to the lowest index when nothing at or above ptr is requesting.
module button_event_arbiter_rr_arbiter #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CODE_W = 2
) (
    input  logic [N_CH-1:0]   req,
    input  logic [CODE_W-1:0] ptr,
    output logic              gnt_any,
    output logic [CODE_W-1:0] gnt_idx
);

    logic              hi_any;
    logic [CODE_W-1:0] hi_idx;
    logic              lo_any;
    logic [CODE_W-1:0] lo_idx;

    // Scan downwards so the last hit written is the lowest index in each half.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = 1'b1;
                lo_idx = CODE_W'(i);
                if (i >= int'(ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = CODE_W'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_any = lo_any;
        gnt_idx = hi_any ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Serialises per-channel event pulses onto one valid/ready port with round-robin
// fairness, a minimum inter-event gap and sticky per-channel overrun flags.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CODE_W     = 2,
    parameter int unsigned GAP_W      = 16,
    parameter int unsigned GAP_CYCLES = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   pulse_in,
    input  logic              ev_ready,
    input  logic              ovr_clr,
    output logic              ev_valid,
    output logic [CODE_W-1:0] ev_code,
    output logic [N_CH-1:0]   ovr,
    output logic              busy
);

    if (CODE_W < clog2(N_CH)) begin : g_code_w_check
        $error("CODE_W is too narrow to encode N_CH channels");
    end

    localparam logic [GAP_W-1:0] GapLoad = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [N_CH-1:0]   ovr_q, ovr_d;
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [GAP_W-1:0]  cnt_q, cnt_d;

    logic [N_CH-1:0]   pend_eff;
    logic              gnt_any;
    logic [CODE_W-1:0] gnt_idx;
    logic [N_CH-1:0]   gnt_vec;
    logic [CODE_W-1:0] ptr_next;

    assign pend_eff = pend_q | pulse_in;

    button_event_arbiter_rr_arbiter #(
        .N_CH   (N_CH),
        .CODE_W (CODE_W)
    ) u_rr_arbiter (
        .req     (pend_eff),
        .ptr     (ptr_q),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        gnt_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            gnt_vec[i] = (state_q == StIdle) && gnt_any && (gnt_idx == CODE_W'(i));
        end
        ptr_next = (code_q == CODE_W'(N_CH - 1)) ? '0 : code_q + 1'b1;
    end

    // A granted channel stays pending only if a fresh pulse lands on it the same cycle.
    always_comb begin
        pend_d = (pend_eff & ~gnt_vec) | (pend_q & pulse_in);
        ovr_d  = (ovr_clr ? '0 : ovr_q) | (pulse_in & pend_q & ~gnt_vec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pend_q  <= '0;
            ovr_q   <= '0;
            ptr_q   <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            ptr_q   <= ptr_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    code_d  = gnt_idx;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (ev_ready) begin
                    ptr_d = ptr_next;
                    if (GAP_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = GapLoad;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ev_valid = (state_q == StSend);
        busy     = (state_q != StIdle);
        ev_code  = code_q;
        ovr      = ovr_q;
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: two instances (gap 4 and gap 0) share directed and
// random stimulus and are compared every cycle against a transaction-level model.
module tb_button_event_arbiter;

    localparam int GapA = 4;
    localparam int GapB = 0;

    typedef struct packed {
        bit [3:0] pend;
        bit [3:0] ovr;
        bit       sending;
        int       code;
        int       ptr;
        int       gap_left;
    } model_t;

    logic       clk;
    logic       reset;
    logic [3:0] pulse_in;
    logic       ev_ready;
    logic       ovr_clr;

    logic       a_ev_valid, b_ev_valid;
    logic [1:0] a_ev_code, b_ev_code;
    logic [3:0] a_ovr, b_ovr;
    logic       a_busy, b_busy;

    int     n_total;
    int     n_bad;
    bit     checking;
    model_t ma, mb;

    button_event_arbiter #(
        .N_CH       (4),
        .CODE_W     (2),
        .GAP_W      (16),
        .GAP_CYCLES (GapA)
    ) u_dut_gap4 (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .ev_ready (ev_ready),
        .ovr_clr  (ovr_clr),
        .ev_valid (a_ev_valid),
        .ev_code  (a_ev_code),
        .ovr      (a_ovr),
        .busy     (a_busy)
    );

    button_event_arbiter #(
        .N_CH       (4),
        .CODE_W     (2),
        .GAP_W      (16),
        .GAP_CYCLES (GapB)
    ) u_dut_gap0 (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .ev_ready (ev_ready),
        .ovr_clr  (ovr_clr),
        .ev_valid (b_ev_valid),
        .ev_code  (b_ev_code),
        .ovr      (b_ovr),
        .busy     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle of the arbiter as seen from its ports: pick, pend, overrun, handshake, gap.
    function automatic model_t model_next(input model_t m, input logic [3:0] p, input logic rdy,
                                          input logic clr, input logic rst, input int gap);
        model_t n;
        int     g;
        int     c;
        n = '0;
        if (rst) return n;
        n = m;
        g = -1;
        if (!m.sending && m.gap_left == 0) begin
            for (int k = 0; k < 4; k++) begin
                c = (m.ptr + k) % 4;
                if (g < 0 && (m.pend[c] || p[c])) g = c;
            end
        end
        if (clr) n.ovr = '0;
        for (int i = 0; i < 4; i++) begin
            if (p[i] && m.pend[i] && i != g) n.ovr[i] = 1'b1;
            n.pend[i] = (i == g) ? (m.pend[i] && p[i]) : (m.pend[i] || p[i]);
        end
        if (m.sending && rdy) begin
            n.ptr      = (m.code + 1) % 4;
            n.sending  = 1'b0;
            n.gap_left = gap;
        end else if (m.gap_left > 0) begin
            n.gap_left = m.gap_left - 1;
        end
        if (g >= 0) begin
            n.sending = 1'b1;
            n.code    = g;
        end
        return n;
    endfunction

    task automatic check_outputs();
        check_eq("a.ev_valid", 32'(a_ev_valid), 32'(ma.sending));
        check_eq("a.ev_code", 32'(a_ev_code), 32'(ma.code));
        check_eq("a.ovr", 32'(a_ovr), 32'(ma.ovr));
        check_eq("a.busy", 32'(a_busy), 32'(ma.sending || ma.gap_left > 0));
        check_eq("b.ev_valid", 32'(b_ev_valid), 32'(mb.sending));
        check_eq("b.ev_code", 32'(b_ev_code), 32'(mb.code));
        check_eq("b.ovr", 32'(b_ovr), 32'(mb.ovr));
        check_eq("b.busy", 32'(b_busy), 32'(mb.sending || mb.gap_left > 0));
    endtask

    task automatic step(input logic [3:0] p, input logic rdy, input logic clr, input logic rst);
        @(negedge clk);
        if (checking) check_outputs();
        pulse_in = p;
        ev_ready = rdy;
        ovr_clr  = clr;
        reset    = rst;
        @(posedge clk);
        ma = model_next(ma, p, rdy, clr, rst, GapA);
        mb = model_next(mb, p, rdy, clr, rst, GapB);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(4'b0000, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        checking = 1'b0;
        ma       = '0;
        mb       = '0;
        pulse_in = '0;
        ev_ready = 1'b0;
        ovr_clr  = 1'b0;
        reset    = 1'b1;
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        checking = 1'b1;
        idle(2, 1'b1);

        // Single event, then gap.
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b1);

        // All channels at once: round-robin order.
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        idle(25, 1'b1);

        // Backpressure with re-pend then overrun on ch1.
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(4'b0010, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(15, 1'b1);

        // Overrun on ch3 colliding with ovr_clr, then ovr_clr alone.
        step(4'b1000, 1'b0, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(15, 1'b1);

        // Reset while in the gap with a pending channel.
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        idle(10, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 199) == 0);
        end
        idle(30, 1'b1);
        step(4'b0000, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
